// File: rtl/tx_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler (master) and the memory streamer/transmitter
// side (slave).
interface tx_frame_scheduler_if;
  logic        data_req;
  logic        sync_now;
  logic        tx_done;
  logic        tx_start;
  logic        tx_sel;
  logic        data_ack;
  logic        tx_abort;
  logic        busy;
  logic [15:0] sync_count;

  modport master (
    input  data_req,
    input  sync_now,
    input  tx_done,
    output tx_start,
    output tx_sel,
    output data_ack,
    output tx_abort,
    output busy,
    output sync_count
  );

  modport slave (
    output data_req,
    output sync_now,
    output tx_done,
    input  tx_start,
    input  tx_sel,
    input  data_ack,
    input  tx_abort,
    input  busy,
    input  sync_count
  );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Schedules payload and resync frames with inter-frame gap and BUSY watchdog.
// Define TX_SCHED_SYNC_EN to build the resync timer, sync_now and sync_count.
module tx_frame_scheduler #(
  parameter int unsigned IFG_CYCLES       = 48,
  parameter int unsigned SYNC_PERIOD      = 1000000,
  parameter int unsigned MAX_FRAME_CYCLES = 100000
) (
  input logic                  clk,
  input logic                  rst,
  tx_frame_scheduler_if.master bus
);

  localparam int unsigned GapW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int unsigned WdW  = (MAX_FRAME_CYCLES > 1) ? $clog2(MAX_FRAME_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(IFG_CYCLES - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(MAX_FRAME_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  state_e          state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            tx_start_q, tx_start_d;
  logic            data_ack_q, data_ack_d;
  logic            abort_q, abort_d;
  logic            tx_sel_q, tx_sel_d;
  logic            busy_q, busy_d;
  logic            sync_req, grant_sync, grant_pay, done_ok;
  logic [15:0]     sync_count;

  // A same-cycle sync_now counts as pending so it beats a coincident data_req.
  assign grant_sync = (state_q == StIdle) & sync_req;
  assign grant_pay  = (state_q == StIdle) & ~sync_req & bus.data_req;
  assign done_ok    = bus.tx_done & ~tx_start_q & ~abort_q;

`ifdef TX_SCHED_SYNC_EN
  localparam int unsigned SyncW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [SyncW-1:0] SyncLast = SyncW'(SYNC_PERIOD - 1);

  logic [SyncW-1:0] sync_tmr_q, sync_tmr_d;
  logic             sync_pend_q, sync_pend_d, sync_wrap;
  logic [15:0]      sync_cnt_q, sync_cnt_d;

  assign sync_req = sync_pend_q | bus.sync_now;

  always_comb begin
    sync_wrap  = (sync_tmr_q == SyncLast);
    sync_tmr_d = sync_wrap ? '0 : sync_tmr_q + 1'b1;
    // sync_now only re-arms on a grant if the grant was serving an older pending request.
    sync_pend_d = sync_wrap | (sync_pend_q & ~grant_sync) |
                  (bus.sync_now & ~(grant_sync & ~sync_pend_q));
    sync_cnt_d  = grant_sync ? sync_cnt_q + 16'd1 : sync_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_tmr_q  <= '0;
      sync_pend_q <= 1'b0;
      sync_cnt_q  <= '0;
    end else begin
      sync_tmr_q  <= sync_tmr_d;
      sync_pend_q <= sync_pend_d;
      sync_cnt_q  <= sync_cnt_d;
    end
  end

  assign sync_count = sync_cnt_q;
`else
  logic unused_sync;
  assign unused_sync = bus.sync_now | (SYNC_PERIOD == 0);
  assign sync_req    = 1'b0;
  assign sync_count  = '0;
`endif

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    wd_d       = wd_q;
    tx_start_d = 1'b0;
    data_ack_d = 1'b0;
    abort_d    = 1'b0;
    tx_sel_d   = tx_sel_q;
    unique case (state_q)
      StIdle: begin
        if (grant_sync || grant_pay) begin
          state_d    = StBusy;
          tx_start_d = 1'b1;
          data_ack_d = grant_pay;
          tx_sel_d   = grant_sync;
          wd_d       = '0;
        end
      end
      StBusy: begin
        // The abort cycle itself is the last BUSY cycle of a timed-out frame.
        if (done_ok || abort_q) begin
          state_d = (IFG_CYCLES == 0) ? StIdle : StGap;
          gap_d   = '0;
        end else if (wd_q == WdLast) begin
          abort_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      wd_q       <= '0;
      tx_start_q <= 1'b0;
      data_ack_q <= 1'b0;
      abort_q    <= 1'b0;
      tx_sel_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      tx_start_q <= tx_start_d;
      data_ack_q <= data_ack_d;
      abort_q    <= abort_d;
      tx_sel_q   <= tx_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.data_ack   = data_ack_q;
  assign bus.tx_abort   = abort_q;
  assign bus.tx_sel     = tx_sel_q;
  assign bus.busy       = busy_q;
  assign bus.sync_count = sync_count;

endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 48, minimum idle clk cycles between end of one frame and next tx_start (0.96 us at 50 MHz).
REQ-002 SHALL have parameter SYNC_PERIOD, default 1000000, clk cycles between automatic resync frames.
REQ-003 SHALL have parameter MAX_FRAME_CYCLES, default 100000, watchdog limit on BUSY duration.
REQ-004 SHALL have port clk  input  1  sole clock (50 MHz domain); all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_req  input  1  level; payload frame ready in upstream memory.
REQ-007 SHALL have port sync_now  input  1  one-cycle pulse; request an immediate resync frame.
REQ-008 SHALL have port tx_done  input  1  one-cycle pulse from transmitter at end of frame.
REQ-009 SHALL have port tx_start  output  1  one-cycle pulse; starts stream-from-memory plus transmitter.
REQ-010 SHALL have port tx_sel  output  1  source select, 0 payload, 1 resync; stable from tx_start until leaving BUSY.
REQ-011 SHALL have port data_ack  output  1  one-cycle pulse coincident with tx_start when tx_sel=0.
REQ-012 SHALL have port tx_abort  output  1  one-cycle pulse on watchdog timeout.
REQ-013 SHALL have port busy  output  1  high in BUSY and GAP.
REQ-014 SHALL have port sync_count  output  16  resync frames started, wraps 0xFFFF->0x0000.

Function
REQ-015 SHALL implement states IDLE, BUSY, GAP; all outputs registered.
REQ-016 SHALL, in IDLE with a request pending at cycle N, enter BUSY and assert tx_start at cycle N+1.
REQ-017 SHALL grant resync over payload when both pending in the same IDLE cycle; payload served on next IDLE.
REQ-018 SHALL ignore tx_done while in IDLE or GAP and in the tx_start cycle itself.
REQ-019 SHALL, on tx_done in BUSY, enter GAP for exactly IFG_CYCLES cycles then IDLE; IFG_CYCLES=0 goes directly to IDLE.
REQ-020 SHALL count BUSY cycles; on reaching MAX_FRAME_CYCLES without tx_done, pulse tx_abort and enter GAP.
REQ-021 SHALL, when tx_done and watchdog expiry coincide, treat as normal completion, no tx_abort.
REQ-022 SHALL free-run sync timer every cycle in all states, wrapping at SYNC_PERIOD-1 and setting sync_pending.
REQ-023 SHALL set sync_pending on sync_now; multiple triggers before service collapse into one pending frame.
REQ-024 SHALL clear sync_pending and increment sync_count on the cycle tx_start issues with tx_sel=1.
REQ-025 SHALL set sync_pending when a trigger coincides with its own clear (new trigger not lost).
REQ-026 SHALL not latch data_req; payload requires data_req high in the IDLE cycle sampled.
REQ-027 SHALL size counters to clog2 of their parameter; no overflow within parameter range.

Reset
REQ-028 SHALL, on rst, force IDLE; tx_start, data_ack, tx_abort, busy, tx_sel = 0; sync_count, timers, sync_pending = 0.
REQ-029 SHALL abandon any in-flight frame on rst mid-BUSY/GAP without tx_abort; first request after rst deasserts issues tx_start no earlier than 2 cycles later.

Configuration
REQ-030 SHALL, with macro TX_SCHED_SYNC_EN defined, implement resync timer, sync_now, sync_pending and sync_count per REQ-022..025.
REQ-031 SHALL, without TX_SCHED_SYNC_EN, ignore sync_now, hold tx_sel and sync_count at 0, schedule payload only.

Verification (IFG_CYCLES=4, SYNC_PERIOD=100, MAX_FRAME_CYCLES=50, macro defined)
REQ-032 SHALL cover: data_req high at cycle 10 -> tx_start, data_ack at 11, tx_sel=0; tx_done at 30 -> GAP 31..34, IDLE 35.
REQ-033 SHALL cover: data_req held high, done every frame -> consecutive tx_start spaced exactly done-to-start 5 cycles.
REQ-034 SHALL cover: sync_now and data_req same IDLE cycle -> sync frame first (tx_sel=1, sync_count=1), payload next after GAP.
REQ-035 SHALL cover: no tx_done after start at cycle 11 -> tx_abort at cycle 61, busy stays high through GAP, IDLE at 66.
REQ-036 SHALL cover: rst asserted mid-BUSY -> next cycle all outputs 0, IDLE; timer restarts, first auto sync pending 100 cycles after rst release.
REQ-037 SHALL cover: macro undefined, sync_now pulses, 300 idle cycles -> no tx_start, sync_count 0.
